// File: rtl/dcim_pkg.sv
// Shared DCIM readout constants and types, common to the multiplier array and the
// result accumulator.
package dcim_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned ADDR_COUNT = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned ACC_WIDTH  = MULT_WIDTH + ADDR_WIDTH;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    S_IDLE,
    S_ACC
  } acc_state_e;

  typedef struct packed {
    logic [7:0]           frame;
    logic [ACC_WIDTH-1:0] sum;
  } result_t;

endpackage

// File: rtl/dcim_result_fifo.sv
// Synchronous result FIFO with a registered head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dcim_result_fifo #(
  parameter int unsigned WIDTH = 45,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  // DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = dout_q;

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    dout_d   = dout_q;
    // The next head is the entry being written when it lands in the head slot.
    if (count_d != '0) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) begin
        dout_d = din;
      end else begin
        dout_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/dcim_result_accumulator.sv
// Sums each frame of ADDR_COUNT multiplier products into one dot-product result and
// buffers the results for a valid/ready consumer, counting results lost to a full buffer.
module dcim_result_accumulator
  import dcim_pkg::*;
#(
  parameter int unsigned MULT_WIDTH = dcim_pkg::MULT_WIDTH,
  parameter int unsigned ADDR_COUNT = dcim_pkg::ADDR_COUNT,
  parameter int unsigned ADDR_WIDTH = dcim_pkg::ADDR_WIDTH,
  parameter int unsigned ACC_WIDTH  = MULT_WIDTH + ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = dcim_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [MULT_WIDTH-1:0] in_data,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [7:0]            out_frame,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  // A one-beat frame still needs a one-bit counter that never leaves zero.
  localparam int unsigned   CntW     = (ADDR_WIDTH > 0) ? ADDR_WIDTH : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(ADDR_COUNT - 1);
  localparam int unsigned   ResW     = ACC_WIDTH + 8;

  acc_state_e           state_q, state_d;
  logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_count_q, drop_count_d;

  logic [ACC_WIDTH-1:0] acc_base, frame_sum;
  logic                 last_beat, push, pop, drop;
  logic                 fifo_full, fifo_empty;
  logic [ResW-1:0]      fifo_din, fifo_dout;

  assign last_beat = (beat_cnt_q == LastBeat);
  assign frame_sum = acc_base + ACC_WIDTH'(in_data);
  assign pop       = ~fifo_empty & out_ready;
  assign drop      = push & fifo_full & ~pop;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (in_valid) begin
      state_d = last_beat ? S_IDLE : S_ACC;
    end
  end

  // FSM outputs: a frame starts from zero in S_IDLE, and a clear swallows the beat.
  always_comb begin
    acc_base = acc_q;
    unique case (state_q)
      S_IDLE:  acc_base = '0;
      S_ACC:   acc_base = acc_q;
      default: acc_base = acc_q;
    endcase
    push = in_valid & ~clear & last_beat;
  end

  always_comb begin
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear) begin
      acc_d        = '0;
      beat_cnt_d   = '0;
      frame_cnt_d  = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (in_valid) begin
      if (last_beat) begin
        acc_d       = '0;
        beat_cnt_d  = '0;
        // Dropped frames still consume a tag so the consumer sees the gap.
        frame_cnt_d = frame_cnt_q + 8'd1;
        if (drop) begin
          overflow_d = 1'b1;
          if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
          end
        end
      end else begin
        acc_d      = frame_sum;
        beat_cnt_d = beat_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign fifo_din = {frame_cnt_q, frame_sum};

  dcim_result_fifo #(
    .WIDTH(ResW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (fifo_din),
    .full (fifo_full),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign out_sum    = fifo_dout[ACC_WIDTH-1:0];
  assign out_frame  = fifo_dout[ResW-1:ACC_WIDTH];
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dcim_result_accumulator.sv
// Bench for dcim_result_accumulator: directed and random beats checked every cycle
// against a frame-level model built from queues.
module tb_dcim_result_accumulator;

  localparam int unsigned AccW   = 37;
  localparam int unsigned Frame  = 32;
  localparam int unsigned Depth  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [31:0]     in_data = '0;
  logic            clear = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [AccW-1:0] out_sum;
  logic [7:0]      out_frame;
  logic            overflow;
  logic [7:0]      drop_count;

  always #5 clk = ~clk;

  dcim_result_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_frame (out_frame),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: beats of the open frame, buffered results, tag counter and drop state.
  longint unsigned cur_beats[$];
  longint unsigned q_sum[$];
  int              q_frame[$];
  int              m_frame;
  bit              m_ovf;
  int              m_drop;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cur_beats.delete();
    q_sum.delete();
    q_frame.delete();
    m_frame = 0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit c, input bit r);
    bit              pop;
    longint unsigned s;
    pop = r && (q_sum.size() > 0);
    if (pop) begin
      void'(q_sum.pop_front());
      void'(q_frame.pop_front());
    end
    if (c) begin
      cur_beats.delete();
      m_frame = 0;
      m_ovf   = 1'b0;
      m_drop  = 0;
    end else if (v) begin
      cur_beats.push_back(longint'(d));
      if (cur_beats.size() == Frame) begin
        s = 0;
        foreach (cur_beats[i]) s += cur_beats[i];
        if (q_sum.size() < Depth) begin
          q_sum.push_back(s);
          q_frame.push_back(m_frame);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
        m_frame = (m_frame + 1) % 256;
        cur_beats.delete();
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, q_sum.size() > 0);
    if (q_sum.size() > 0) begin
      check_eq("out_sum", out_sum, q_sum[0]);
      check_eq("out_frame", out_frame, q_frame[0]);
    end
    check_eq("overflow", overflow, m_ovf);
    check_eq("drop_count", drop_count, m_drop);
  endtask

  // One clock: check state left by the previous edge, drive inputs, advance the model.
  task automatic cycle(input bit v, input logic [31:0] d, input bit c, input bit r);
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_data   = d;
    clear     = c;
    out_ready = r;
    @(posedge clk);
    model_step(v, d, c, r);
  endtask

  task automatic frame_const(input logic [31:0] d, input bit r);
    for (int i = 0; i < Frame; i++) cycle(1'b1, d, 1'b0, r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_out_valid"}, out_valid, 0);
    check_eq({pfx, "_out_sum"}, out_sum, 0);
    check_eq({pfx, "_out_frame"}, out_frame, 0);
    check_eq({pfx, "_overflow"}, overflow, 0);
    check_eq({pfx, "_drop_count"}, drop_count, 0);
  endtask

  initial begin
    model_reset();

    // Reset values, then one frame of ones with a ready consumer.
    do_reset();
    #1;
    check_zero_outputs("reset");
    frame_const(32'd1, 1'b1);
    #1;
    check_eq("latency_valid", out_valid, 1);
    check_eq("ones_sum", out_sum, 32);
    check_eq("ones_frame", out_frame, 0);
    idle(3, 1'b1);

    // Largest products: the sum must not wrap.
    frame_const(32'hFFFF_FFFF, 1'b0);
    idle(1, 1'b0);
    #1;
    check_eq("max_sum", out_sum, 64'h1F_FFFF_FFE0);
    idle(3, 1'b1);

    // Five frames into a stalled consumer: one drop, then drain four results.
    do_reset();
    for (int f = 0; f < 5; f++) frame_const(32'd3, 1'b0);
    idle(1, 1'b0);
    #1;
    check_eq("stall_overflow", overflow, 1);
    check_eq("stall_drop_count", drop_count, 1);
    check_eq("stall_head_sum", out_sum, 96);
    idle(6, 1'b1);
    #1;
    check_eq("drained_valid", out_valid, 0);

    // Full FIFO with a pop on the fifth final beat: nothing is dropped.
    do_reset();
    for (int f = 0; f < 4; f++) frame_const($urandom, 1'b0);
    for (int i = 0; i < Frame - 1; i++) cycle(1'b1, 32'd5, 1'b0, 1'b0);
    cycle(1'b1, 32'd5, 1'b0, 1'b1);
    idle(2, 1'b0);
    #1;
    check_eq("full_pop_overflow", overflow, 0);
    check_eq("full_pop_head_tag", out_frame, 1);
    idle(6, 1'b1);

    // A clear mid-frame discards the partial sum and the beat that rides with it.
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'd7, 1'b0, 1'b1);
    cycle(1'b1, 32'd7, 1'b1, 1'b1);
    frame_const(32'd2, 1'b0);
    idle(1, 1'b0);
    #1;
    check_eq("clear_sum", out_sum, 64);
    check_eq("clear_frame", out_frame, 0);
    idle(3, 1'b1);

    // Random data, valid gaps, ready toggling and occasional clears.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0);
    end
    idle(6, 1'b1);

    // Long stall: drop_count saturates and tags wrap past 255.
    do_reset();
    for (int f = 0; f < 262; f++) frame_const($urandom, 1'b0);
    idle(1, 1'b0);
    #1;
    check_eq("sat_drop_count", drop_count, 255);
    idle(6, 1'b1);
    frame_const($urandom, 1'b1);
    idle(1, 1'b0);
    #1;
    check_eq("wrap_tag", out_frame, 6);
    idle(3, 1'b1);

    // Asynchronous reset mid-frame with a result still buffered.
    frame_const($urandom, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'd9, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame_const(32'd1, 1'b0);
    idle(1, 1'b0);
    #1;
    check_eq("post_rst_sum", out_sum, 32);
    check_eq("post_rst_frame", out_frame, 0);
    idle(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcim_result_accumulator.md
# dcim_result_accumulator

Downstream stage of `sram_multiplier_system`. It consumes the 32-bit product stream (`data_out` qualified by `valid_out`) and sums each frame of `ADDR_COUNT` consecutive products into one dot-product result. Results are buffered in a small FIFO and presented on a valid/ready output. It is the first stage of the DCIM readout path, between the multiplier array and the result bus.

## Interface
Parameters:
- `MULT_WIDTH`, 32, width of one incoming product
- `ADDR_COUNT`, 32, products per frame (power of two)
- `ADDR_WIDTH`, 5, log2(`ADDR_COUNT`)
- `ACC_WIDTH`, `MULT_WIDTH+ADDR_WIDTH` (37), result width; overflow is impossible
- `FIFO_DEPTH`, 4, result buffer entries (power of two)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  product beat valid; wired to multiplier `valid_out`
- `in_data`  in  `MULT_WIDTH`  unsigned product; wired to multiplier `data_out`
- `clear`  in  1  synchronous frame restart, pulsed alongside multiplier re-init
- `out_valid`  out  1  FIFO head holds a result
- `out_ready`  in  1  consumer accepts head
- `out_sum`  out  `ACC_WIDTH`  frame sum at FIFO head
- `out_frame`  out  8  frame tag of head result
- `overflow`  out  1  sticky: at least one result dropped
- `drop_count`  out  8  dropped results, saturating at 255

## Operation
- There is no input backpressure, because the multiplier cannot stall. Every `in_valid` beat is consumed.
- Internal registers: `beat_cnt` (`ADDR_WIDTH` bits), `acc` (`ACC_WIDTH` bits), `frame_cnt` (8 bits, wraps 255→0).
- Beat counter FSM:
  - `S_IDLE` (`beat_cnt==0`, `acc==0`): on a beat, go to `S_ACC`, `acc=in_data`, `beat_cnt=1`.
  - `S_ACC`: each beat does `acc+=in_data` (zero-extended) and `beat_cnt+=1`.
  - On the beat where `beat_cnt==ADDR_COUNT-1`: push `acc+in_data` with tag `frame_cnt`, then `acc=0`, `beat_cnt=0`, `frame_cnt+=1`, and return to `S_IDLE`.
- Gaps in `in_valid` hold all state.
- With `ADDR_COUNT==1`, every beat completes a frame.
- Push when FIFO is full and there is no pop in the same cycle:
  - The result is dropped.
  - `overflow` is set.
  - `drop_count` increments.
  - `frame_cnt` still increments, so drops appear as tag gaps.
- Push and pop in the same cycle while full: the push is accepted, and the count stays `FIFO_DEPTH`.
- Push and pop in the same cycle while empty: the push is written, the pop is ignored (`out_valid` was 0), and the count goes to 1.
- Pop occurs when `out_valid && out_ready`.
- `clear` takes priority over any same-cycle beat.
  - It zeroes `acc`, `beat_cnt`, `frame_cnt`, `overflow` and `drop_count`, and returns to `S_IDLE`.
  - A beat in that cycle is discarded.
  - FIFO contents are kept and remain poppable.
- Arithmetic is unsigned with no saturation, since `ACC_WIDTH` always suffices.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - `out_valid=0`, `out_sum=0`, `out_frame=0`, `overflow=0`, `drop_count=0`
  - FSM in `S_IDLE`, FIFO empty.
- Latency: a final beat sampled at edge N gives `out_valid=1` after edge N (visible in cycle N+1) when the FIFO was empty.
- `out_sum` and `out_frame` are registered FIFO head outputs and hold stable while `out_valid && !out_ready`.
- Throughput: one result per `ADDR_COUNT` beats, and one pop per cycle.
- Reset asserted mid-frame discards the partial sum and all FIFO contents immediately.

## Structure
- `dcim_pkg` holds:
  - `MULT_WIDTH`, `ADDR_COUNT`, `ADDR_WIDTH`, `ACC_WIDTH` localparams shared with `sram_multiplier_system`
  - the FSM state enum `{S_IDLE, S_ACC}`
  - the result struct `{frame[7:0], sum[ACC_WIDTH-1:0]}`.
- Sub-module `dcim_result_fifo`:
  - synchronous FIFO, parameterised width and depth
  - ports: `push`, `din`, `full`, `pop`, `dout`, `empty`
  - registered `dout`, same-cycle push/pop supported when full.
- The top level contains the FSM, accumulator, counters and drop logic.

## Test plan
- Reset, then 32 beats of `in_data=1` back-to-back with `out_ready=1` → exactly one result, `out_sum=32`, `out_frame=0`, one cycle after the last beat.
- 32 beats of `0xFFFFFFFF` → `out_sum=0x1FFFFFFFE0` (2^37−32), no wrap.
- `out_ready=0` while 5 frames of `in_data=3` complete:
  - FIFO holds 4 results of 96 with tags 0–3, and `overflow=1`, `drop_count=1`.
  - Then raise `out_ready` → 4 pops, after which `out_valid=0`.
- FIFO full, `out_ready=1` in the same cycle as the frame-5 final beat → no drop, `overflow=0`, and the popped tag 0 is followed later by tag 4.
- 10 beats of `in_data=7`, pulse `clear` (with `in_valid=1`), then 32 beats of 2 → single result `out_sum=64`, `out_frame=0`.
- Random `in_valid` gaps over 32 beats of random data → `out_sum` equals the scoreboard sum. Assert `rst_n` mid-frame → outputs return to reset values asynchronously.
